// File: rtl/num_ram_pkg.sv
// Shared types and default sizing for the multi-port number store and its clear sequencer.
package num_ram_pkg;

  typedef enum logic {
    CLR_IDLE,
    CLR_ACTIVE
  } clr_state_e;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_DEPTH      = 2048;

endpackage

// File: rtl/num_ram_clear_ctrl.sv
// Ranged clear sequencer: walks ptr from base for cnt words (wrapping at DEPTH-1),
// emitting one fill write per cycle, with busy level and a done pulse.
module num_ram_clear_ctrl
  import num_ram_pkg::*;
#(
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_start,
  input  logic [ADDR_WIDTH-1:0] clr_base,
  input  logic [ADDR_WIDTH:0]   clr_len,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr,
  output logic                  clr_busy,
  output logic                  clr_done,
  output logic                  clr_last_full
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_C   = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   ONE_C     = (ADDR_WIDTH+1)'(1);

  clr_state_e            state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [ADDR_WIDTH:0]   cnt;
  logic                  full;
  logic                  start_full;

  // Zero length or anything at/above DEPTH means the whole array.
  assign start_full = (clr_len == '0) || (clr_len >= DEPTH_C);

  // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= CLR_IDLE;
      ptr      <= '0;
      cnt      <= '0;
      full     <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      case (state)
        CLR_IDLE: begin
          if (clr_start) begin
            state <= CLR_ACTIVE;
            ptr   <= ({1'b0, clr_base} >= DEPTH_C) ? '0 : clr_base;
            cnt   <= start_full ? DEPTH_C : clr_len;
            full  <= start_full;
          end
        end
        CLR_ACTIVE: begin
          ptr <= (ptr == LAST_ADDR) ? '0 : ptr + 1'b1;
          cnt <= cnt - 1'b1;
          if (cnt == ONE_C) begin
            state    <= CLR_IDLE;
            clr_done <= 1'b1;
          end
        end
        default: state <= CLR_IDLE;
      endcase
    end
  end

  assign clr_busy      = (state == CLR_ACTIVE);
  assign clr_we        = clr_busy;
  assign clr_addr      = ptr;
  assign clr_last_full = clr_busy && full && (cnt == ONE_C);

endmodule

// File: rtl/num_storage_ram_mp.sv
// Multi-read-port number store: one write port shared with the clear sequencer,
// NUM_RD registered read ports with optional write-first bypass, and a high-water mark.
module num_storage_ram_mp
  import num_ram_pkg::*;
#(
  parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int                    DEPTH      = DEF_DEPTH,
  parameter int                    ADDR_WIDTH = $clog2(DEPTH),
  parameter int                    NUM_RD     = 2,
  parameter logic [DATA_WIDTH-1:0] FILL_VALUE = '0,
  parameter bit                    WR_BYPASS  = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [ADDR_WIDTH-1:0]        wr_addr,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  output logic                         wr_err,
  input  logic [NUM_RD-1:0]            rd_en,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]            rd_valid,
  input  logic                         clr_start,
  input  logic [ADDR_WIDTH-1:0]        clr_base,
  input  logic [ADDR_WIDTH:0]          clr_len,
  output logic                         clr_busy,
  output logic                         clr_done,
  output logic [ADDR_WIDTH:0]          hwm
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);

  logic                  clr_we;
  logic                  clr_last_full;
  logic [ADDR_WIDTH-1:0] clr_addr;

  num_ram_clear_ctrl #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_clear (
    .clk           (clk),
    .rst_n         (rst_n),
    .clr_start     (clr_start),
    .clr_base      (clr_base),
    .clr_len       (clr_len),
    .clr_we        (clr_we),
    .clr_addr      (clr_addr),
    .clr_busy      (clr_busy),
    .clr_done      (clr_done),
    .clr_last_full (clr_last_full)
  );

  logic                  wr_ok;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [ADDR_WIDTH:0]   wr_next;

  // User writes are refused while the clear owns the port, so the mux only needs clr_we.
  assign wr_ok     = wr_en && !clr_busy && ({1'b0, wr_addr} < DEPTH_C);
  assign mem_we    = clr_we || wr_ok;
  assign mem_addr  = clr_we ? clr_addr : wr_addr;
  assign mem_wdata = clr_we ? FILL_VALUE : wr_data;
  assign wr_next   = {1'b0, wr_addr} + (ADDR_WIDTH+1)'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset; contents are only defined after a write or clear.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] q;
    logic                  valid_q;
    logic                  in_range;
    logic                  hit;

    assign addr     = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign in_range = ({1'b0, addr} < DEPTH_C);
    assign hit      = WR_BYPASS && mem_we && (mem_addr == addr);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q       <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= rd_en[i];
        if (rd_en[i]) begin
          if (!in_range) q <= FILL_VALUE;
          else if (hit)  q <= mem_wdata;
          else           q <= mem[addr];
        end
      end
    end

    assign rd_data[i*DATA_WIDTH +: DATA_WIDTH] = q;
    assign rd_valid[i]                         = valid_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hwm    <= '0;
      wr_err <= 1'b0;
    end else begin
      wr_err <= wr_en && !wr_ok;
      if (clr_last_full)                 hwm <= '0;
      else if (wr_ok && (wr_next > hwm)) hwm <= wr_next;
    end
  end

endmodule
